sysarr_mac_ctrl: RTL and testbench
==================================

# sysarr_mac_ctrl

Step sequencer for a row of N systolic-array MAC units that share one `MAC_shift`/`start` pair. It accepts a job of `job_len` input vectors and, for each vector, shifts the vector into the MACs and fires one multiply-accumulate. It then waits for every MAC's `value_ready` and pulses a capture strobe so the partial-sum registers latch `out_accumulate`. It sits between the input-vector buffer and the MAC row, and is the only driver of the MAC control inputs.

## Interface
Parameters:
- `N`, 4, number of MAC units in the row.
- `CNT_W`, 8, width of job length and step counter.
- `TIMEOUT`, 64, maximum WAIT cycles before a step is aborted (≥ 2).

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `nRST`  in  1  reset; asynchronous, active-low.
- `job_valid`  in  1  job request.
- `job_len`  in  CNT_W  number of input vectors in the job; 0 is legal.
- `job_ready`  out  1  controller can accept a job (high only in IDLE).
- `in_valid`  in  1  input buffer holds a vector on the MAC `in_value` bus.
- `in_ready`  out  1  vector consumed this cycle.
- `mac_shift`  out  1  to all `MAC_shift`.
- `mac_start`  out  1  to all `start`.
- `mac_value_ready`  in  N  per-MAC `value_ready`.
- `acc_sel`  out  1  partial-sum mux: 0 = zero into `in_accumulate`, 1 = fed-back partial sum.
- `acc_capture`  out  1  latch `out_accumulate` into the partial-sum registers.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle job completion pulse.
- `step_cnt`  out  CNT_W  completed steps in the current job.
- `err_timeout`  out  1  sticky: a step timed out in the current or last job.

## Operation
- The FSM has the states IDLE, LOAD, FIRE, WAIT, CAPTURE and DONE. All outputs are Moore outputs except `in_ready`/`mac_shift`.
- **IDLE**
  - `job_ready`=1.
  - On `job_valid`, latch `len` and clear `step_cnt`, `err_timeout` and the wait counter.
  - Go to DONE if `job_len`==0, else go to LOAD.
- **LOAD**
  - `in_ready`=`mac_shift`=`in_valid` (same cycle).
  - On `in_valid`, go to FIRE. Otherwise stay, with no timeout.
- **FIRE**
  - `mac_start`=1 for exactly one cycle.
  - Clear the wait counter and go to WAIT.
- **WAIT**
  - If `&mac_value_ready`, go to CAPTURE.
  - Otherwise increment the wait counter. When it reaches `TIMEOUT`, set `err_timeout` and go to DONE without capture.
  - `value_ready` is already low in FIRE, because the MAC's run is combinational on `start`. No masking is needed.
- **CAPTURE**
  - `acc_capture`=1.
  - `step_cnt` += 1.
  - If the new `step_cnt`==`len`, go to DONE; else go to LOAD.
- **DONE**: `done`=1, then go to IDLE.
- `acc_sel` = (`step_cnt`≠0). It is held stable through LOAD/FIRE/WAIT/CAPTURE of each step, so step 0 accumulates onto zero.
- `mac_shift` and `mac_start` are never high in the same cycle. `mac_start` is never high outside FIRE.
- `job_valid` is ignored outside IDLE. `in_valid` is ignored outside LOAD.
- `step_cnt` holds its final value after DONE until the next job is accepted.
- `len` = 2^CNT_W−1 must complete without wrap.

## Timing
- **Reset values:** state IDLE, `job_ready`=1, every other output 0, internal counters 0.
- Asserting `nRST` mid-job forces IDLE and the reset output values immediately, with no done pulse.
- **Per-step latency** with `in_valid` already high and all MACs ready after W WAIT cycles (W≥1): LOAD 1 + FIRE 1 + WAIT W + CAPTURE 1 = W+3 cycles.
- **Job latency:**
  - Accept at cycle t0: `done` is high at cycle t0+1+L·(W+3).
  - `job_len`=0: `done` at t0+1.
  - `job_ready` returns the cycle after `done`. Back-to-back jobs have 1 idle cycle minimum.
- **Timeout:** `err_timeout` rises in the DONE cycle entered after `TIMEOUT` WAIT cycles. It stays high until the next job accept.
- **Partial readiness:** any single `mac_value_ready` bit low holds WAIT.

## Test plan
- **Reset:** drive `nRST`=0 with random inputs, release → `job_ready`=1, all other outputs 0, no `mac_start` for 10 cycles with `job_valid`=0.
- **Nominal job:**
  - Stimulus: `job_len`=3, `in_valid` held high, MAC model raising ready 4 cycles after start.
  - Required response: exactly 3 `mac_shift`, 3 `mac_start` and 3 `acc_capture` pulses; `acc_sel`=0 on the first step, then 1.
  - `done` at t0+1+3·7=t0+22, `step_cnt`=3.
- **Input starvation:** `job_len`=2, `in_valid` low for 5 cycles in step 2 → controller stays in LOAD with `mac_shift`=0. Job completes after `in_valid` rises, with no timeout.
- **Zero length:** `job_len`=0 → `done` one cycle after accept, with no `mac_shift`, `mac_start` or `acc_capture`.
- **Timeout:** N=4, one MAC's ready bit stuck low, `TIMEOUT`=64 → `err_timeout`=1 and `done` after 64 WAIT cycles, no `acc_capture`. The next accepted job clears `err_timeout`.
- **Reset mid-WAIT:** assert `nRST` during step 2 of 4 → outputs return to reset values asynchronously, no `done`. A new job with `job_len`=1 then runs normally.

Source files
------------

// File: rtl/sysarr_mac_ctrl.sv
// Step sequencer for a row of systolic-array MAC units sharing one shift/start pair.
// Per input vector: shift it in, fire one MAC, wait for every MAC to be ready, then capture the partial sums.
module sysarr_mac_ctrl #(
    parameter int N       = 4,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             job_valid,
    input  logic [CNT_W-1:0] job_len,
    output logic             job_ready,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             mac_shift,
    output logic             mac_start,
    input  logic [N-1:0]     mac_value_ready,
    output logic             acc_sel,
    output logic             acc_capture,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] step_cnt,
    output logic             err_timeout
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FIRE,
        WAIT,
        CAPTURE,
        DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  len;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  next_step;
    logic              all_ready;

    assign all_ready = &mac_value_ready;
    assign next_step = step_cnt + CNT_W'(1);

    // The vector handshake is the only combinational path: a vector is consumed the same cycle it is offered in LOAD.
    assign in_ready  = (state == LOAD) && in_valid;
    assign mac_shift = in_ready;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            len         <= '0;
            wait_cnt    <= '0;
            job_ready   <= 1'b1;
            mac_start   <= 1'b0;
            acc_capture <= 1'b0;
            acc_sel     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            step_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            mac_start   <= 1'b0;
            acc_capture <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (job_valid) begin
                        len         <= job_len;
                        step_cnt    <= '0;
                        err_timeout <= 1'b0;
                        wait_cnt    <= '0;
                        acc_sel     <= 1'b0;
                        job_ready   <= 1'b0;
                        busy        <= 1'b1;
                        if (job_len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        state     <= FIRE;
                        mac_start <= 1'b1;
                    end
                end
                FIRE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                // Abort the step after TIMEOUT cycles without every MAC ready; no capture in that case.
                WAIT: begin
                    if (all_ready) begin
                        state       <= CAPTURE;
                        acc_capture <= 1'b1;
                    end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                        wait_cnt    <= wait_cnt + WAIT_W'(1);
                        err_timeout <= 1'b1;
                        state       <= DONE;
                        done        <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                CAPTURE: begin
                    step_cnt <= next_step;
                    acc_sel  <= 1'b1;
                    if (next_step == len) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= LOAD;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    job_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    job_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysarr_mac_ctrl.sv
// Self-checking bench for sysarr_mac_ctrl: a job-level reference model predicts every output each cycle,
// and directed scenarios pin exact latencies and pulse counts with hand-computed values.
module tb_sysarr_mac_ctrl;

    localparam int N       = 4;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             nRST = 1'b0;
    logic             job_valid = 1'b0;
    logic [CNT_W-1:0] job_len = '0;
    logic             in_valid = 1'b0;
    logic [N-1:0]     mac_value_ready = '0;
    logic             job_ready, in_ready, mac_shift, mac_start;
    logic             acc_sel, acc_capture, busy, done, err_timeout;
    logic [CNT_W-1:0] step_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    sysarr_mac_ctrl #(.N(N), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .nRST(nRST), .job_valid(job_valid), .job_len(job_len), .job_ready(job_ready),
        .in_valid(in_valid), .in_ready(in_ready), .mac_shift(mac_shift), .mac_start(mac_start),
        .mac_value_ready(mac_value_ready), .acc_sel(acc_sel), .acc_capture(acc_capture), .busy(busy),
        .done(done), .step_cnt(step_cnt), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Environment: in_valid source and a MAC row whose readiness rises a chosen number of cycles after start.
    int iv_mode = 1;
    int fix_w = 0;
    logic [N-1:0] stuck = '0;
    int mac_age = 0;
    int dly [N];

    initial forever begin
        @(posedge clk);
        #3;
        if (iv_mode == 0) in_valid = 1'b1;
        else if (iv_mode == 1) in_valid = (($urandom % 4) != 0);
    end

    initial forever begin
        @(negedge clk);
        if (mac_start === 1'b1) begin
            mac_age = 0;
            for (int i = 0; i < N; i++)
                dly[i] = (fix_w > 0) ? fix_w : (($urandom_range(0, 19) == 0) ? 200 : int'($urandom_range(1, 8)));
            mac_value_ready = '0;
        end else begin
            if (mac_age < 100000) mac_age++;
            for (int i = 0; i < N; i++) mac_value_ready[i] = (mac_age >= dly[i]) && !stuck[i];
        end
    end

    // Observation counters for the directed checks.
    int n_shift = 0, n_start = 0, n_cap = 0, n_done = 0, done_cyc = -1;
    logic accsel_q [$];

    initial forever begin
        @(negedge clk);
        if (nRST) begin
            if (mac_shift) n_shift++;
            if (mac_start) begin
                n_start++;
                accsel_q.push_back(acc_sel);
            end
            if (acc_capture) n_cap++;
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    // Reference model: walks a job step by step from sampled inputs and publishes what each cycle must show.
    bit e_jr = 1'b1, e_load = 1'b0, e_start = 1'b0, e_cap = 1'b0, e_busy = 1'b0, e_done = 1'b0;
    bit m_err = 1'b0;
    int m_step = 0;
    int rst_count = 0, m_seen = 0;
    bit m_abort = 1'b0;
    logic s_job_valid, s_in_valid, s_ready;
    logic [CNT_W-1:0] s_job_len;

    initial forever begin
        @(negedge nRST);
        rst_count++;
    end

    function automatic void set_exp(input bit jr, input bit ld, input bit st, input bit cp, input bit bz, input bit dn);
        e_jr = jr; e_load = ld; e_start = st; e_cap = cp; e_busy = bz; e_done = dn;
    endfunction

    function automatic void model_reset();
        m_step = 0;
        m_err = 1'b0;
        m_seen = rst_count;
        m_abort = 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        s_job_valid = job_valid;
        s_job_len = job_len;
        s_in_valid = in_valid;
        s_ready = &mac_value_ready;
        if (rst_count != m_seen || !nRST) m_abort = 1'b1;
        #1;
    endtask

    task automatic model_job(input int len);
        bit timed_out = 1'b0;
        int waited;
        m_step = 0;
        m_err = 1'b0;
        for (int s = 0; s < len; s++) begin
            do begin
                set_exp(0, 1, 0, 0, 1, 0);
                tick();
                if (m_abort) return;
            end while (!s_in_valid);
            set_exp(0, 0, 1, 0, 1, 0);
            tick();
            if (m_abort) return;
            waited = 0;
            forever begin
                set_exp(0, 0, 0, 0, 1, 0);
                tick();
                if (m_abort) return;
                if (s_ready) break;
                waited++;
                if (waited == TIMEOUT) begin
                    timed_out = 1'b1;
                    break;
                end
            end
            if (timed_out) break;
            set_exp(0, 0, 0, 1, 1, 0);
            tick();
            if (m_abort) return;
            m_step++;
        end
        if (timed_out) m_err = 1'b1;
        set_exp(0, 0, 0, 0, 1, 1);
        tick();
    endtask

    initial forever begin
        set_exp(1, 0, 0, 0, 0, 0);
        tick();
        if (m_abort) model_reset();
        else if (s_job_valid) model_job(int'(s_job_len));
        if (m_abort) model_reset();
    end

    logic [16:0] actv, expv;
    always @(negedge clk) begin
        actv = {job_ready, in_ready, mac_shift, mac_start, acc_sel, acc_capture, busy, done, err_timeout, step_cnt};
        if (!nRST) expv = 17'h10000;
        else expv = {e_jr, e_load & in_valid, e_load & in_valid, e_start, m_step != 0, e_cap, e_busy, e_done,
                     m_err, CNT_W'(m_step)};
        checkOutput("cycle outputs {jr,ir,sh,st,sel,cap,busy,done,err,step}", 32'(actv), 32'(expv));
    end

    // Stimulus helpers; callers are always positioned 3 time units after a rising edge.
    int done_base = 0, sh_base = 0, st_base = 0, cap_base = 0;

    task automatic applyStimulus(input int len, output int t0);
        int guard = 0;
        while (job_ready !== 1'b1 && guard < 500) begin
            @(posedge clk);
            #3;
            guard++;
        end
        checkOutput("job_ready before accept", 32'(job_ready), 32'd1);
        done_base = n_done; sh_base = n_shift; st_base = n_start; cap_base = n_cap;
        job_valid = 1'b1;
        job_len = CNT_W'(len);
        t0 = cyc;
        @(posedge clk);
        #3;
        job_valid = 1'b0;
        job_len = CNT_W'($urandom);
    endtask

    task automatic waitDone(input int budget);
        int k = 0;
        while (n_done == done_base && k < budget) begin
            @(posedge clk);
            #3;
            k++;
        end
        checkOutput("done pulses for job", 32'(n_done - done_base), 32'd1);
    endtask

    task automatic waitStarts(input int target, input int budget);
        int k = 0;
        while (n_start < target && k < budget) begin
            @(posedge clk);
            #3;
            k++;
        end
        checkOutput("mac_start reached", 32'(n_start >= target), 32'd1);
    endtask

    initial begin
        int t0, t1, k;
        iv_mode = 1;
        nRST = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #3;
            job_valid = 1'($urandom);
            job_len = CNT_W'($urandom);
        end
        job_valid = 1'b0;
        nRST = 1'b1;
        repeat (10) begin
            @(negedge clk);
            checkOutput("post-reset mac_start", 32'(mac_start), 32'd0);
            checkOutput("post-reset job_ready", 32'(job_ready), 32'd1);
        end
        @(posedge clk);
        #3;

        // Nominal: three steps, ready 4 cycles after start -> 7 cycles per step.
        iv_mode = 0; fix_w = 4;
        accsel_q.delete();
        applyStimulus(3, t0);
        waitDone(200);
        checkOutput("nominal done cycle", 32'(done_cyc), 32'(t0 + 22));
        checkOutput("nominal shifts", 32'(n_shift - sh_base), 32'd3);
        checkOutput("nominal starts", 32'(n_start - st_base), 32'd3);
        checkOutput("nominal captures", 32'(n_cap - cap_base), 32'd3);
        checkOutput("nominal step_cnt", 32'(step_cnt), 32'd3);
        checkOutput("nominal acc_sel samples", 32'(accsel_q.size()), 32'd3);
        if (accsel_q.size() == 3) begin
            checkOutput("acc_sel step0", 32'(accsel_q[0]), 32'd0);
            checkOutput("acc_sel step1", 32'(accsel_q[1]), 32'd1);
            checkOutput("acc_sel step2", 32'(accsel_q[2]), 32'd1);
        end

        // Starvation: in_valid drops during step 2's LOAD for five cycles.
        iv_mode = 2; in_valid = 1'b1; fix_w = 3;
        applyStimulus(2, t0);
        waitStarts(st_base + 1, 100);
        in_valid = 1'b0;
        k = 0;
        while (n_cap == cap_base && k < 100) begin
            @(posedge clk);
            #3;
            k++;
        end
        repeat (5) begin
            @(negedge clk);
            checkOutput("starved mac_shift", 32'(mac_shift), 32'd0);
            checkOutput("starved busy", 32'(busy), 32'd1);
        end
        @(posedge clk);
        #3;
        in_valid = 1'b1;
        iv_mode = 0;
        waitDone(200);
        checkOutput("starved step_cnt", 32'(step_cnt), 32'd2);
        checkOutput("starved err_timeout", 32'(err_timeout), 32'd0);
        checkOutput("starved starts", 32'(n_start - st_base), 32'd2);

        // Zero-length job.
        applyStimulus(0, t0);
        waitDone(10);
        checkOutput("zero-len done cycle", 32'(done_cyc), 32'(t0 + 1));
        checkOutput("zero-len shifts", 32'(n_shift - sh_base), 32'd0);
        checkOutput("zero-len starts", 32'(n_start - st_base), 32'd0);
        checkOutput("zero-len captures", 32'(n_cap - cap_base), 32'd0);

        // Timeout: one MAC never ready; LOAD, FIRE, 64 WAIT cycles, then DONE.
        stuck = 4'b0100; fix_w = 2;
        applyStimulus(3, t0);
        waitDone(200);
        checkOutput("timeout done cycle", 32'(done_cyc), 32'(t0 + 67));
        checkOutput("timeout err_timeout", 32'(err_timeout), 32'd1);
        checkOutput("timeout captures", 32'(n_cap - cap_base), 32'd0);
        checkOutput("timeout step_cnt", 32'(step_cnt), 32'd0);
        stuck = '0;
        applyStimulus(1, t1);
        @(negedge clk);
        checkOutput("err cleared on accept", 32'(err_timeout), 32'd0);
        waitDone(100);
        checkOutput("post-timeout step_cnt", 32'(step_cnt), 32'd1);

        // Reset during step 2's WAIT.
        fix_w = 6;
        applyStimulus(4, t0);
        waitStarts(st_base + 2, 200);
        nRST = 1'b0;
        #1;
        checkOutput("async reset busy", 32'(busy), 32'd0);
        checkOutput("async reset job_ready", 32'(job_ready), 32'd1);
        checkOutput("async reset step_cnt", 32'(step_cnt), 32'd0);
        checkOutput("async reset acc_sel", 32'(acc_sel), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #3;
        end
        nRST = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #3;
        end
        checkOutput("no done after reset", 32'(n_done - done_base), 32'd0);
        applyStimulus(1, t1);
        waitDone(100);
        checkOutput("after-reset done cycle", 32'(done_cyc), 32'(t1 + 10));
        checkOutput("after-reset step_cnt", 32'(step_cnt), 32'd1);

        // Longest job: 255 steps at 4 cycles each, no counter wrap.
        fix_w = 1;
        applyStimulus(255, t0);
        waitDone(2000);
        checkOutput("max-len done cycle", 32'(done_cyc), 32'(t0 + 1021));
        checkOutput("max-len step_cnt", 32'(step_cnt), 32'd255);
        checkOutput("max-len captures", 32'(n_cap - cap_base), 32'd255);

        // Randomized jobs: random lengths, input gaps and per-MAC readiness (occasional timeouts).
        iv_mode = 1; fix_w = 0;
        for (int j = 0; j < 12; j++) begin
            int len;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #3;
            end
            len = $urandom_range(0, 6);
            applyStimulus(len, t0);
            waitDone(len * 120 + 100);
        end

        repeat (3) begin
            @(posedge clk);
            #3;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
